// File: rtl/biquad_zero_coeff_sequencer_if.sv
// ============================================================================
//  biquad_zero_coeff_sequencer_if
//  Register-bus and FIR coefficient-port bundle for the zero-coeff sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface biquad_zero_coeff_sequencer_if #(
   parameter int NCHAN      = 8,
   parameter int CHAN_BITS  = 3,
   parameter int COEFF_BITS = 18
);
   logic                  wr_i;
   logic [CHAN_BITS:0]    wr_addr_i;
   logic [COEFF_BITS-1:0] wr_dat_i;
   logic [NCHAN-1:0]      update_req_i;
   logic [COEFF_BITS-1:0] coeff_dat_o;
   logic [NCHAN-1:0]      coeff_wr_o;
   logic [NCHAN-1:0]      coeff_update_o;
   logic [NCHAN-1:0]      pending_o;
   logic                  busy_o;
   logic                  done_o;

   modport master (
      output wr_i, wr_addr_i, wr_dat_i, update_req_i,
      input  coeff_dat_o, coeff_wr_o, coeff_update_o, pending_o, busy_o, done_o
   );

   modport slave (
      input  wr_i, wr_addr_i, wr_dat_i, update_req_i,
      output coeff_dat_o, coeff_wr_o, coeff_update_o, pending_o, busy_o, done_o
   );
endinterface

`default_nettype wire

// File: rtl/biquad_zero_coeff_sequencer.sv
// ============================================================================
//  biquad_zero_coeff_sequencer
//  Round-robin b/a/update load sequencer for NCHAN biquad zero-FIR instances.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module biquad_zero_coeff_sequencer #(
   parameter int NCHAN      = 8,
   parameter int CHAN_BITS  = 3,
   parameter int COEFF_BITS = 18
) (
   input  logic clk,
   input  logic rst_n,
   biquad_zero_coeff_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_LOAD_A = 3'd3,
      ST_UPDATE = 3'd4
   } state_t;

   localparam logic [CHAN_BITS:0]   NCHAN_W  = (CHAN_BITS+1)'(NCHAN);
   localparam logic [CHAN_BITS-1:0] LAST_RST = CHAN_BITS'(NCHAN-1);
   localparam logic [NCHAN-1:0]     ONE      = NCHAN'(1);

   state_t                state_q, state_d;
   logic [COEFF_BITS-1:0] b_q [NCHAN];
   logic [COEFF_BITS-1:0] a_q [NCHAN];
   logic [COEFF_BITS-1:0] b_snap_q, b_snap_d, a_snap_q, a_snap_d;
   logic [NCHAN-1:0]      pending_q, pending_d;
   logic [CHAN_BITS-1:0]  last_q, last_d, chan_q, chan_d;
   logic                  done_q, done_d;

   logic [NCHAN-1:0]      start_mask;
   logic [CHAN_BITS-1:0]  pick;
   logic                  pick_vld;
   logic [CHAN_BITS-1:0]  wr_chan;
   logic                  wr_ok;
   logic [NCHAN-1:0]      chan_onehot;

   assign wr_chan     = bus.wr_addr_i[CHAN_BITS:1];
   assign wr_ok       = bus.wr_i && ({1'b0, wr_chan} < NCHAN_W);
   assign chan_onehot = ONE << chan_q;

   // First pending channel strictly after the last serviced one, with wrap.
   always_comb begin : blk_rr_pick
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= NCHAN; k++) begin
         idx = (int'(last_q) + k) % NCHAN;
         if (!pick_vld && pending_q[idx[CHAN_BITS-1:0]]) begin
            pick_vld = 1'b1;
            pick     = idx[CHAN_BITS-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      last_d     = last_q;
      b_snap_d   = b_snap_q;
      a_snap_d   = a_snap_q;
      start_mask = '0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (pick_vld) begin
               chan_d     = pick;
               last_d     = pick;
               b_snap_d   = b_q[pick];
               a_snap_d   = a_q[pick];
               start_mask = ONE << pick;
               state_d    = ST_LOAD_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_B: state_d = ST_LOAD_A;
         ST_LOAD_A: state_d = ST_UPDATE;
         ST_UPDATE: begin
            // Same-cycle requests chain straight into the next selection.
            if (|(pending_q | bus.update_req_i)) begin
               state_d = ST_SELECT;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pending_d = (pending_q | bus.update_req_i) & ~start_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCHAN; i++) begin
            b_q[i] <= '0;
            a_q[i] <= '0;
         end
         state_q   <= ST_IDLE;
         b_snap_q  <= '0;
         a_snap_q  <= '0;
         pending_q <= '0;
         last_q    <= LAST_RST;
         chan_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         if (wr_ok) begin
            if (bus.wr_addr_i[0]) a_q[wr_chan] <= bus.wr_dat_i;
            else                  b_q[wr_chan] <= bus.wr_dat_i;
         end
         state_q   <= state_d;
         b_snap_q  <= b_snap_d;
         a_snap_q  <= a_snap_d;
         pending_q <= pending_d;
         last_q    <= last_d;
         chan_q    <= chan_d;
         done_q    <= done_d;
      end
   end

   assign bus.coeff_dat_o    = (state_q == ST_LOAD_B) ? b_snap_q :
                               (state_q == ST_LOAD_A) ? a_snap_q : '0;
   assign bus.coeff_wr_o     = (state_q == ST_LOAD_B || state_q == ST_LOAD_A) ? chan_onehot : '0;
   assign bus.coeff_update_o = (state_q == ST_UPDATE) ? chan_onehot : '0;
   assign bus.pending_o      = pending_q;
   assign bus.busy_o         = (state_q != ST_IDLE) || (|pending_q);
   assign bus.done_o         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_biquad_zero_coeff_sequencer.sv
// ============================================================================
//  tb_biquad_zero_coeff_sequencer
//  Directed and randomized bench with a cycle-schedule reference model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_biquad_zero_coeff_sequencer;

   localparam int NCHAN      = 8;
   localparam int CHAN_BITS  = 3;
   localparam int COEFF_BITS = 18;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   biquad_zero_coeff_sequencer_if #(.NCHAN(NCHAN), .CHAN_BITS(CHAN_BITS), .COEFF_BITS(COEFF_BITS)) bus ();

   biquad_zero_coeff_sequencer #(.NCHAN(NCHAN), .CHAN_BITS(CHAN_BITS), .COEFF_BITS(COEFF_BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: each cycle is a slot describing what the outputs must show.
   typedef struct {
      bit                    sel;
      logic [NCHAN-1:0]      wr;
      logic [NCHAN-1:0]      upd;
      logic [COEFF_BITS-1:0] dat;
      bit                    done;
   } slot_t;

   logic [COEFF_BITS-1:0] m_b [NCHAN];
   logic [COEFF_BITS-1:0] m_a [NCHAN];
   logic [NCHAN-1:0]      m_pend;
   int                    m_last;
   slot_t                 m_cur;
   slot_t                 m_sched [$];
   bit                    m_valid = 1'b0;

   function automatic slot_t idle_slot();
      slot_t s;
      s.sel = 1'b0; s.wr = '0; s.upd = '0; s.dat = '0; s.done = 1'b0;
      return s;
   endfunction

   function automatic int rr_pick(logic [NCHAN-1:0] p, int l);
      for (int k = 1; k <= NCHAN; k++) begin
         int c;
         c = (l + k) % NCHAN;
         if (p[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCHAN; i++) begin m_b[i] = '0; m_a[i] = '0; end
         m_pend  = '0;
         m_last  = NCHAN - 1;
         m_cur   = idle_slot();
         m_sched.delete();
         m_valid = 1'b1;
      end else if (m_valid) begin
         logic [NCHAN-1:0] req, newpend;
         slot_t nxt, s;
         int ch, wch;
         req     = bus.update_req_i;
         newpend = m_pend | req;
         if (m_cur.sel) begin
            ch = rr_pick(m_pend, m_last);
            if (ch >= 0) begin
               m_last = ch;
               s = idle_slot(); s.wr  = NCHAN'(1) << ch; s.dat = m_b[ch]; m_sched.push_back(s);
               s = idle_slot(); s.wr  = NCHAN'(1) << ch; s.dat = m_a[ch]; m_sched.push_back(s);
               s = idle_slot(); s.upd = NCHAN'(1) << ch;                  m_sched.push_back(s);
               newpend = newpend & ~(NCHAN'(1) << ch);
            end
         end
         if (m_sched.size() > 0) begin
            nxt = m_sched.pop_front();
         end else if (|m_cur.upd) begin
            nxt = idle_slot();
            if (|(m_pend | req)) nxt.sel = 1'b1;
            else                 nxt.done = 1'b1;
         end else begin
            nxt = idle_slot();
            nxt.sel = |m_pend;
         end
         if (bus.wr_i) begin
            wch = int'(bus.wr_addr_i[CHAN_BITS:1]);
            if (wch < NCHAN) begin
               if (bus.wr_addr_i[0]) m_a[wch] = bus.wr_dat_i;
               else                  m_b[wch] = bus.wr_dat_i;
            end
         end
         m_pend = newpend;
         m_cur  = nxt;
      end
   end

   // Per-cycle comparison plus event logs for the directed checks.
   logic [COEFF_BITS-1:0] wr_log  [$];
   int                    upd_log [$];
   int done_cnt = 0, wr_cycles = 0, upd_cycles = 0;

   always @(negedge clk) begin
      if (m_valid) begin
         bit exp_busy;
         exp_busy = m_cur.sel || (|m_cur.wr) || (|m_cur.upd) || (|m_pend);
         tests_run++;
         if (bus.coeff_dat_o !== m_cur.dat || bus.coeff_wr_o !== m_cur.wr ||
             bus.coeff_update_o !== m_cur.upd || bus.pending_o !== m_pend ||
             bus.busy_o !== exp_busy || bus.done_o !== m_cur.done) begin
            tests_failed++;
            $display("FAIL cycle_cmp t=%0t (dut/model) dat=%h/%h wr=%h/%h upd=%h/%h pend=%h/%h busy=%b/%b done=%b/%b",
                     $time, bus.coeff_dat_o, m_cur.dat, bus.coeff_wr_o, m_cur.wr,
                     bus.coeff_update_o, m_cur.upd, bus.pending_o, m_pend,
                     bus.busy_o, exp_busy, bus.done_o, m_cur.done);
         end
         if (bus.coeff_wr_o != '0) begin wr_log.push_back(bus.coeff_dat_o); wr_cycles++; end
         if (bus.coeff_update_o != '0) begin
            for (int i = 0; i < NCHAN; i++) if (bus.coeff_update_o[i]) upd_log.push_back(i);
            upd_cycles++;
         end
         if (bus.done_o) done_cnt++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.wr_i         = 1'b0;
      bus.update_req_i = '0;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input int ch, input bit sel_a, input logic [COEFF_BITS-1:0] d);
      bus.wr_i      = 1'b1;
      bus.wr_addr_i = {CHAN_BITS'(ch), sel_a};
      bus.wr_dat_i  = d;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      steps(2);
      rst_n = 1'b1;
   endtask

   task automatic clear_logs();
      wr_log.delete(); upd_log.delete();
      done_cnt = 0; wr_cycles = 0; upd_cycles = 0;
   endtask

   initial begin
      bus.wr_i         = 1'b0;
      bus.wr_addr_i    = '0;
      bus.wr_dat_i     = '0;
      bus.update_req_i = '0;

      // Single channel: exact latency and data.
      do_reset();
      chk("reset_busy", bus.busy_o, 0);
      chk("reset_pend", bus.pending_o, 0);
      wr(2, 1'b0, 18'h0F000);
      wr(2, 1'b1, 18'h04000);
      bus.update_req_i = 8'h04;
      step();
      chk("t1_pend", bus.pending_o, 8'h04);
      chk("t1_busy", bus.busy_o, 1);
      steps(2);
      chk("t1_wr_b", bus.coeff_wr_o, 8'h04);
      chk("t1_dat_b", bus.coeff_dat_o, 18'h0F000);
      step();
      chk("t1_wr_a", bus.coeff_wr_o, 8'h04);
      chk("t1_dat_a", bus.coeff_dat_o, 18'h04000);
      step();
      chk("t1_upd", bus.coeff_update_o, 8'h04);
      chk("t1_upd_nowr", bus.coeff_wr_o, 8'h00);
      step();
      chk("t1_done", bus.done_o, 1);
      chk("t1_idle", bus.busy_o, 0);
      step();
      chk("t1_done_pulse", bus.done_o, 0);

      // All channels from reset.
      do_reset();
      clear_logs();
      bus.update_req_i = 8'hFF;
      step();
      chk("t2_pend0", bus.pending_o, 8'hFF);
      steps(2);
      chk("t2_pend1", bus.pending_o, 8'hFE);
      steps(40);
      chk("t2_upd_cnt", upd_log.size(), 8);
      for (int i = 0; i < 8 && i < upd_log.size(); i++) chk("t2_order", upd_log[i], i);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_wr_cycles", wr_cycles, 16);
      chk("t2_upd_cycles", upd_cycles, 8);

      // Round-robin wrap after servicing ch5.
      bus.update_req_i = 8'h20;
      step();
      steps(8);
      clear_logs();
      bus.update_req_i = 8'h21;
      step();
      steps(12);
      chk("t3_cnt", upd_log.size(), 2);
      if (upd_log.size() == 2) begin
         chk("t3_first", upd_log[0], 0);
         chk("t3_second", upd_log[1], 5);
      end

      // Re-request and write during LOAD_A of ch1.
      wr(1, 1'b0, 18'h00111);
      wr(1, 1'b1, 18'h00222);
      clear_logs();
      bus.update_req_i = 8'h02;
      step();
      steps(3);
      chk("t4_in_load_a", bus.coeff_dat_o, 18'h00222);
      bus.update_req_i = 8'h02;
      bus.wr_i         = 1'b1;
      bus.wr_addr_i    = {3'd1, 1'b0};
      bus.wr_dat_i     = 18'h1FFFF;
      step();
      steps(10);
      chk("t4_wr_cnt", wr_log.size(), 4);
      if (wr_log.size() == 4) begin
         chk("t4_b_old", wr_log[0], 18'h00111);
         chk("t4_a_old", wr_log[1], 18'h00222);
         chk("t4_b_new", wr_log[2], 18'h1FFFF);
         chk("t4_a_new", wr_log[3], 18'h00222);
      end
      chk("t4_upd_cnt", upd_log.size(), 2);

      // Reset during LOAD_A.
      wr(3, 1'b0, 18'h12345);
      wr(3, 1'b1, 18'h0ABCD);
      clear_logs();
      bus.update_req_i = 8'h08;
      step();
      steps(3);
      chk("t5_pre_dat", bus.coeff_dat_o, 18'h0ABCD);
      rst_n = 1'b0;
      step();
      chk("t5_wr", bus.coeff_wr_o, 0);
      chk("t5_upd", bus.coeff_update_o, 0);
      chk("t5_pend", bus.pending_o, 0);
      chk("t5_busy", bus.busy_o, 0);
      rst_n = 1'b1;
      steps(4);
      chk("t5_no_update", upd_log.size(), 0);
      clear_logs();
      bus.update_req_i = 8'h08;
      step();
      steps(6);
      chk("t5_reload_cnt", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk("t5_b_zero", wr_log[0], 0);
         chk("t5_a_zero", wr_log[1], 0);
      end

      // Writes alone never start a load.
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         bus.wr_i      = 1'b1;
         bus.wr_addr_i = (CHAN_BITS+1)'($urandom);
         bus.wr_dat_i  = COEFF_BITS'($urandom);
         step();
      end
      chk("t6_busy", bus.busy_o, 0);
      chk("t6_no_strobes", wr_log.size() + upd_log.size(), 0);

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.wr_i         = 1'($urandom_range(0, 1));
         bus.wr_addr_i    = (CHAN_BITS+1)'($urandom);
         bus.wr_dat_i     = COEFF_BITS'($urandom);
         bus.update_req_i = ($urandom_range(0, 7) == 0) ? NCHAN'($urandom) : '0;
         rst_n            = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      steps(60);
      chk("final_idle", bus.busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
